// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the iterative long multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } mult_fsm_t;

  function automatic int calc_iter(input int data_width, input int pps);
    return data_width / pps;
  endfunction

  // Counter is at least one bit wide even when a single pass covers all of B.
  function automatic int calc_cnt_w(input int data_width, input int pps);
    int iter;
    iter = data_width / pps;
    return (iter <= 1) ? 1 : $clog2(iter);
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/pipelined_long_multiplier_stage.sv
// One long-multiplication step: adds A * (PPS-bit slice of B) to the running high
// accumulator {carry, partial} and splits off the PPS settled low bits.
module pipelined_long_multiplier_stage #(
  parameter int DATA_WIDTH        = 8,
  parameter int PRODUCT_PER_STAGE = 4
) (
  input  logic [DATA_WIDTH-1:0]        operand_a_i,
  input  logic [PRODUCT_PER_STAGE-1:0] operand_b_i,
  input  logic [DATA_WIDTH-2:0]        partial_product_i,
  input  logic                         carry_i,
  output logic [DATA_WIDTH-2:0]        partial_product_o,
  output logic                         carry_o,
  output logic [PRODUCT_PER_STAGE-1:0] final_result_bits_o
);

  localparam int SUM_W = DATA_WIDTH + PRODUCT_PER_STAGE;

  // The high accumulator never exceeds DATA_WIDTH bits, so SUM_W cannot overflow.
  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = {{PRODUCT_PER_STAGE{1'b0}}, carry_i, partial_product_i};
    for (int i = 0; i < PRODUCT_PER_STAGE; i++) begin
      if (operand_b_i[i]) begin
        sum = sum + (SUM_W'(operand_a_i) << i);
      end
    end
  end

  assign final_result_bits_o        = sum[PRODUCT_PER_STAGE-1:0];
  assign {carry_o, partial_product_o} = sum[SUM_W-1:PRODUCT_PER_STAGE];

endmodule

// File: rtl/iterative_long_multiplier_ctrl.sv
// Multi-cycle unsigned multiplier reusing one long-multiplier stage; consumes
// PRODUCT_PER_STAGE bits of B per cycle and hands the product off over valid/ready.
module iterative_long_multiplier_ctrl
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int PRODUCT_PER_STAGE = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [DATA_WIDTH-1:0]   operand_A_i,
  input  logic [DATA_WIDTH-1:0]   operand_B_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [2*DATA_WIDTH-1:0] product_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o,
  output mult_fsm_t               state_o
);

  localparam int DW    = DATA_WIDTH;
  localparam int PPS   = PRODUCT_PER_STAGE;
  localparam int ITER  = calc_iter(DW, PPS);
  localparam int CNT_W = calc_cnt_w(DW, PPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  if (!is_pow2(DW) || (DW < 2) || !is_pow2(PPS) || (PPS > DW)) begin : g_bad_params
    $error("iterative_long_multiplier_ctrl: illegal DATA_WIDTH/PRODUCT_PER_STAGE");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. ready_o never looks at valid_i; upstream holds operands until accepted,
  // downstream sees product_o stable for as long as valid_o is high.

  mult_fsm_t          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DW-1:0]      a_q;
  logic [DW-1:0]      b_q;
  logic [DW-2:0]      part_q;
  logic               carry_q;
  logic [2*DW-1:0]    product_q;

  logic [DW-2:0]      st_part;
  logic               st_carry;
  logic [PPS-1:0]     st_bits;
  logic [2*DW-1:0]    result_next;

  logic               accept;
  logic               last_iter;

  assign ready_o   = (state_q == IDLE) | ((state_q == DONE) & ready_i);
  assign accept    = valid_i & ready_o;
  assign last_iter = (state_q == COMPUTE) && (cnt_q == LAST_CNT);

  assign valid_o   = (state_q == DONE);
  assign busy_o    = (state_q == COMPUTE);
  assign product_o = product_q;
  assign state_o   = state_q;

  pipelined_long_multiplier_stage #(
    .DATA_WIDTH        (DW),
    .PRODUCT_PER_STAGE (PPS)
  ) u_stage (
    .operand_a_i         (a_q),
    .operand_b_i         (b_q[PPS-1:0]),
    .partial_product_i   (part_q),
    .carry_i             (carry_q),
    .partial_product_o   (st_part),
    .carry_o             (st_carry),
    .final_result_bits_o (st_bits)
  );

  if (ITER == 1) begin : g_single
    assign result_next = {st_carry, st_part, st_bits};
  end else begin : g_multi
    // Settled low digits, filled LSB-first from the top so the oldest digit
    // ends up in the lowest position.
    logic [DW-1:0] low_q;

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        low_q <= '0;
      end else if (accept) begin
        low_q <= '0;
      end else if (state_q == COMPUTE) begin
        low_q <= {st_bits, low_q[DW-1:PPS]};
      end
    end

    assign result_next = {st_carry, st_part, st_bits, low_q[DW-1:PPS]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      part_q    <= '0;
      carry_q   <= 1'b0;
      product_q <= '0;
    end else if (accept) begin
      state_q <= COMPUTE;
      cnt_q   <= '0;
      a_q     <= operand_A_i;
      b_q     <= operand_B_i;
      part_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        COMPUTE: begin
          part_q  <= st_part;
          carry_q <= st_carry;
          b_q     <= b_q >> PPS;
          if (last_iter) begin
            product_q <= result_next;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_long_multiplier_ctrl.sv
// Bench for iterative_long_multiplier_ctrl: ITER=2 (PPS=4) and ITER=1 (PPS=8) instances,
// directed vectors plus randomised operands with output backpressure.
module tb_iterative_long_multiplier_ctrl;
  import mult_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic [7:0]  a0, b0, a1, b1;
  logic        v0, v1, rdy_i0, rdy_i1;
  logic        ready_o0, ready_o1, vo0, vo1, busy0, busy1;
  logic [15:0] p0, p1;
  mult_fsm_t   st0, st1;

  iterative_long_multiplier_ctrl #(.DATA_WIDTH(8), .PRODUCT_PER_STAGE(4)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .operand_A_i(a0), .operand_B_i(b0), .valid_i(v0),
    .ready_o(ready_o0), .product_o(p0), .valid_o(vo0), .ready_i(rdy_i0),
    .busy_o(busy0), .state_o(st0)
  );

  iterative_long_multiplier_ctrl #(.DATA_WIDTH(8), .PRODUCT_PER_STAGE(8)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .operand_A_i(a1), .operand_B_i(b1), .valid_i(v1),
    .ready_o(ready_o1), .product_o(p1), .valid_o(vo1), .ready_i(rdy_i1),
    .busy_o(busy1), .state_o(st1)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int          exp_cyc_q0[$];
  int          exp_cyc_q1[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] wa, wb;
    wa = {8'd0, a};
    wb = {8'd0, b};
    return wa * wb;
  endfunction

  // ---------------- monitors ----------------
  bit pv0 = 0, phs0 = 0, pv1 = 0, phs1 = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (vo0) begin
        if (exp_q0.size() == 0) begin
          check("dut0_spurious_valid", 32'(vo0), 32'd0);
        end else begin
          if (!pv0) check("dut0_latency", cyc, exp_cyc_q0[0]);
          check("dut0_product", 32'(p0), 32'(exp_q0[0]));
          if (rdy_i0) begin
            void'(exp_q0.pop_front());
            void'(exp_cyc_q0.pop_front());
          end
        end
      end else if (pv0 && !phs0) begin
        check("dut0_valid_dropped", 32'(vo0), 32'd1);
      end
      pv0  = vo0;
      phs0 = vo0 && rdy_i0;
    end else begin
      pv0  = 0;
      phs0 = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (vo1) begin
        if (exp_q1.size() == 0) begin
          check("dut1_spurious_valid", 32'(vo1), 32'd0);
        end else begin
          if (!pv1) check("dut1_latency", cyc, exp_cyc_q1[0]);
          check("dut1_product", 32'(p1), 32'(exp_q1[0]));
          if (rdy_i1) begin
            void'(exp_q1.pop_front());
            void'(exp_cyc_q1.pop_front());
          end
        end
      end else if (pv1 && !phs1) begin
        check("dut1_valid_dropped", 32'(vo1), 32'd1);
      end
      pv1  = vo1;
      phs1 = vo1 && rdy_i1;
    end else begin
      pv1  = 0;
      phs1 = 0;
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int idx, input logic [7:0] a, input logic [7:0] b,
                      output bit in_done);
    bit got;
    in_done = 0;
    got     = 0;
    if (idx == 0) begin a0 = a; b0 = b; v0 = 1'b1; end
    else          begin a1 = a; b1 = b; v1 = 1'b1; end
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (idx == 0 && ready_o0) begin
        got = 1; in_done = vo0;
        exp_q0.push_back(ref_mul(a, b));
        exp_cyc_q0.push_back(cyc + 1 + 2);
      end else if (idx == 1 && ready_o1) begin
        got = 1; in_done = vo1;
        exp_q1.push_back(ref_mul(a, b));
        exp_cyc_q1.push_back(cyc + 1 + 1);
      end
    end
    if (!got) check("send_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (exp_q0.size() != 0 || exp_q1.size() != 0); k++) begin
      @(posedge clk);
    end
    check("drain_q0_empty", 32'(exp_q0.size()), 32'd0);
    check("drain_q1_empty", 32'(exp_q1.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Random backpressure on both outputs while enabled.
  bit bp_en = 0;
  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      rdy_i0 = 1'($urandom_range(0, 1));
      rdy_i1 = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit d1, d2;
    rst_n = 1'b0;
    a0 = '0; b0 = '0; v0 = 1'b0; rdy_i0 = 1'b0;
    a1 = '0; b1 = '0; v1 = 1'b0; rdy_i1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_ready0",   32'(ready_o0), 32'd1);
    check("rst_valid0",   32'(vo0),      32'd0);
    check("rst_busy0",    32'(busy0),    32'd0);
    check("rst_product0", 32'(p0),       32'd0);
    check("rst_state0",   32'(st0),      32'(IDLE));
    check("rst_ready1",   32'(ready_o1), 32'd1);
    check("rst_product1", 32'(p1),       32'd0);
    @(posedge clk);
    #1;

    // 0xFF*0xFF, immediate handoff, product retained afterwards
    rdy_i0 = 1'b1;
    send(0, 8'hFF, 8'hFF, d1);
    @(negedge clk);
    check("compute_busy0", 32'(busy0), 32'd1);
    check("compute_ready0", 32'(ready_o0), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("after_handoff_valid0", 32'(vo0), 32'd0);
    check("after_handoff_product0", 32'(p0), 32'hFE01);
    check("after_handoff_state0", 32'(st0), 32'(IDLE));
    @(posedge clk);
    #1;

    // 0x0D*0x0B held under backpressure
    rdy_i0 = 1'b0;
    send(0, 8'h0D, 8'h0B, d1);
    repeat (7) @(posedge clk);
    #1 rdy_i0 = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back: second accepted in the first's DONE cycle
    send(0, 8'h12, 8'h34, d1);
    send(0, 8'h80, 8'h02, d2);
    check("b2b_first_from_idle", 32'(d1), 32'd0);
    check("b2b_second_in_done",  32'(d2), 32'd1);
    drain();

    // Reset during the first COMPUTE cycle discards the operation
    send(0, 8'hFF, 8'hFF, d1);
    rst_n = 1'b0;
    @(negedge clk);
    check("pre_reset_busy0", 32'(busy0), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q0.delete();
    exp_cyc_q0.delete();
    @(negedge clk);
    check("mid_rst_state0",   32'(st0),   32'(IDLE));
    check("mid_rst_busy0",    32'(busy0), 32'd0);
    check("mid_rst_product0", 32'(p0),    32'd0);
    for (int k = 0; k < 5; k++) begin
      check("mid_rst_no_valid0", 32'(vo0), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    // ITER=1 instance
    rdy_i1 = 1'b1;
    send(1, 8'hA5, 8'h5A, d1);
    drain();

    // Random operands with random backpressure
    bp_en = 1;
    for (int i = 0; i < 12; i++) begin
      send(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), d1);
    end
    for (int i = 0; i < 8; i++) begin
      send(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), d1);
    end
    send(0, 8'h00, 8'hFF, d1);
    send(1, 8'hFF, 8'h01, d1);
    @(posedge clk);
    bp_en = 0;
    #2;
    rdy_i0 = 1'b1;
    rdy_i1 = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
